stall_flush_ctrl: RTL and testbench
===================================

Name: stall_flush_ctrl

Overview:
- Central pipeline sequencer for the 5-stage MIPS core.
- Sits beside the IF/ID, ID/EX and EX/MEM registers and drives their write-enables, flush and bubble controls.
- Resolves four hazard sources under one fixed priority: data-memory wait, taken branch, multi-cycle mult/div occupancy, and load-use.
- Tracks mult/div busy time with an internal counter and keeps a saturating stall-cycle counter.

Parameters:
- MULT_CYCLES, 4: EX-occupancy cycles of a mult/multu.
- DIV_CYCLES, 32: EX-occupancy cycles of a div/divu.
- CNT_W, 6: width of the mult/div countdown; must hold DIV_CYCLES-1.
- STALL_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  synchronous, active-high.
- idex_memread  in  1  instruction in EX is a load.
- idex_rt  in  5  destination register of the load in EX.
- ifid_rs  in  5  rs of the instruction in ID.
- ifid_rt  in  5  rt of the instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt as a source.
- ifid_is_mdu  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- branch_taken  in  1  branch/jump resolved taken in EX.
- mdu_start  in  1  mult/div enters EX this cycle.
- mdu_is_div  in  1  qualifies mdu_start (1 = div).
- dmem_req  in  1  MEM stage is accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to nop.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  select zero controls into ID/EX.
- exmem_write  out  1  EX/MEM load enable.
- mdu_busy  out  1  mult/div unit is occupied.
- mdu_done  out  1  one-cycle pulse on the last busy cycle.
- stall_count  out  STALL_W  number of cycles with pc_write=0; saturates.

Behaviour:
- Registered state: mode {RUN, MDU_BUSY}, mdu_cnt[CNT_W], stall_count. Control outputs are combinational from this state and the inputs, so they act in the same cycle.
- Default (no hazard): all write-enables 1, ifid_flush 0, idex_bubble 0.
- Priority, highest first:
  - P1 mem freeze: dmem_req && !dmem_ready. pc_write, ifid_write, idex_write and exmem_write are all 0. No flush and no bubble. Lower-priority conditions are suppressed and re-evaluated once the freeze lifts, so a branch held in EX flushes on the release cycle.
  - P2 branch: branch_taken. pc_write=1, ifid_flush=1, idex_bubble=1. Overrides P3 and P4 because the ID instruction is on the wrong path.
  - P3 mdu hazard: mode==MDU_BUSY && ifid_is_mdu. pc_write=0, ifid_write=0, idex_bubble=1.
  - P4 load-use: idex_memread && idex_rt!=0 && (idex_rt==ifid_rs || (ifid_uses_rt && idex_rt==ifid_rt)). pc_write=0, ifid_write=0, idex_bubble=1. Exactly one bubble per occurrence.
- Register $0 never causes a load-use stall.
- MDU FSM:
  - In RUN, mdu_start loads mdu_cnt = (mdu_is_div ? DIV_CYCLES : MULT_CYCLES)-1 and moves to MDU_BUSY.
  - In MDU_BUSY, mdu_busy=1 and mdu_cnt decrements every cycle, including during P1 freezes.
  - When mdu_cnt==0 in MDU_BUSY: mdu_done=1, next mode RUN. The ID stall releases the following cycle.
  - A cycle-count parameter of 1 gives a single MDU_BUSY cycle, with mdu_done asserted in it.
  - mdu_start while in MDU_BUSY is illegal and ignored. Verification flags it with an assertion.
  - mdu_start in the same cycle as branch_taken cannot occur (both would be in EX), so it needs no handling.
- stall_count increments on every cycle where pc_write==0. It holds at all-ones and does not wrap.
- Reset, checked at the clock edge and taking effect from any state, including mid-MDU or mid-freeze:
  - Registered state: mode=RUN, mdu_cnt=0, stall_count=0.
  - While reset is high: pc_write, ifid_write, idex_write and exmem_write are 0; ifid_flush=1, idex_bubble=1; mdu_busy=0, mdu_done=0.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the mode enum {RUN, MDU_BUSY};
  - REG_ZERO = 5'd0;
  - the default MULT_CYCLES and DIV_CYCLES constants;
  - a packed struct for the six pipeline control outputs.
- One sub-module, mdu_timer, contains the countdown, the busy/done logic and the load on start. The top level holds the priority encoder and stall_count.

Test Plan:
- Load-use: lw $5 in EX (idex_memread=1, idex_rt=5), ID has ifid_rs=5 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then defaults; stall_count=1. Repeat with idex_rt=0 -> no stall.
- Branch beats load-use: branch_taken=1 together with a load-use match -> pc_write=1, ifid_flush=1, idex_bubble=1; stall_count unchanged.
- Divide: mdu_start=1, mdu_is_div=1 -> mdu_busy high for exactly 32 cycles with mdu_done on the 32nd. An ifid_is_mdu=1 instruction held in ID stalls through cycle 32 and proceeds on cycle 33. Run the same with a multiply -> 4 busy cycles.
- Mem freeze during branch: dmem_req=1, dmem_ready=0 for 3 cycles with branch_taken=1 -> all write-enables 0, ifid_flush=0 for those 3 cycles; on the release cycle ifid_flush=1 and idex_bubble=1.
- Reset mid-divide: assert reset at busy cycle 10 -> the next cycle shows mdu_busy=0, mode RUN, stall_count=0. No mdu_done pulse occurs.
- Saturation: with STALL_W=4, hold a load-use stall for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer: MDU mode, control bundle,
// default mult/div latencies and the load-use match function.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_mode_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int MULT_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF  = 32;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                      idex_write: 1'b1, idex_bubble: 1'b0, exmem_write: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                         idex_write: 1'b0, idex_bubble: 1'b0, exmem_write: 1'b0};
  localparam pipe_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                        idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1};
  // Stall holds PC and IF/ID but keeps ID/EX and EX/MEM moving so the bubble advances.
  localparam pipe_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        idex_write: 1'b1, idex_bubble: 1'b1, exmem_write: 1'b1};
  localparam pipe_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                        idex_write: 1'b0, idex_bubble: 1'b1, exmem_write: 1'b0};

  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       uses_rt);
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/stall_flush_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the datapath
// (master) and the stall/flush sequencer (slave).
interface stall_flush_ctrl_if #(
  parameter int STALL_W = 16
);
  logic               idex_memread;
  logic [4:0]         idex_rt;
  logic [4:0]         ifid_rs;
  logic [4:0]         ifid_rt;
  logic               ifid_uses_rt;
  logic               ifid_is_mdu;
  logic               branch_taken;
  logic               mdu_start;
  logic               mdu_is_div;
  logic               dmem_req;
  logic               dmem_ready;

  logic               pc_write;
  logic               ifid_write;
  logic               ifid_flush;
  logic               idex_write;
  logic               idex_bubble;
  logic               exmem_write;
  logic               mdu_busy;
  logic               mdu_done;
  logic [STALL_W-1:0] stall_count;

  modport master (
    output idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_mdu,
           branch_taken, mdu_start, mdu_is_div, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           mdu_busy, mdu_done, stall_count
  );

  modport slave (
    input  idex_memread, idex_rt, ifid_rs, ifid_rt, ifid_uses_rt, ifid_is_mdu,
           branch_taken, mdu_start, mdu_is_div, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write,
           mdu_busy, mdu_done, stall_count
  );

endinterface

// File: rtl/stall_flush_ctrl_mdu_timer.sv
// Mult/div occupancy timer: loads a countdown on start and reports busy/done
// until the last occupied EX cycle.
module mdu_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  mdu_mode_e        mode_reg, mode_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg <= RUN;
      cnt_reg  <= '0;
    end else begin
      mode_reg <= mode_next;
      cnt_reg  <= cnt_next;
    end
  end

  // A start arriving while busy is illegal upstream and simply ignored here.
  always_comb begin
    mode_next = mode_reg;
    cnt_next  = cnt_reg;
    case (mode_reg)
      RUN: begin
        if (start) begin
          cnt_next  = is_div ? DIV_LOAD : MULT_LOAD;
          mode_next = MDU_BUSY;
        end
      end
      MDU_BUSY: begin
        if (cnt_reg == '0) begin
          mode_next = RUN;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        mode_next = RUN;
        cnt_next  = '0;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (!reset && (mode_reg == MDU_BUSY)) begin
      busy = 1'b1;
      done = (cnt_reg == '0);
    end
  end

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline sequencer: prioritises memory freeze, taken branch, MDU and load-use
// hazards into register enables, and counts PC-stall cycles with saturation.
module stall_flush_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 6,
  parameter int STALL_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  stall_flush_ctrl_if.slave bus
);

  logic               mdu_busy;
  logic               mdu_done;
  logic               mem_freeze;
  logic               mdu_hazard;
  logic               load_use;
  pipe_ctrl_t         ctrl;
  logic [STALL_W-1:0] stall_count_reg;

  mdu_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .start (bus.mdu_start),
    .is_div(bus.mdu_is_div),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  assign mem_freeze = bus.dmem_req && !bus.dmem_ready;
  assign mdu_hazard = mdu_busy && bus.ifid_is_mdu;
  assign load_use   = load_use_hit(bus.idex_memread, bus.idex_rt, bus.ifid_rs,
                                   bus.ifid_rt, bus.ifid_uses_rt);

  // A freeze masks everything below it, so a branch held in EX flushes on release.
  always_comb begin
    ctrl = CTRL_RUN;
    if (reset) begin
      ctrl = CTRL_RESET;
    end else if (mem_freeze) begin
      ctrl = CTRL_FREEZE;
    end else if (bus.branch_taken) begin
      ctrl = CTRL_FLUSH;
    end else if (mdu_hazard || load_use) begin
      ctrl = CTRL_STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!ctrl.pc_write && (stall_count_reg != '1)) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign bus.pc_write    = ctrl.pc_write;
  assign bus.ifid_write  = ctrl.ifid_write;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_write  = ctrl.idex_write;
  assign bus.idex_bubble = ctrl.idex_bubble;
  assign bus.exmem_write = ctrl.exmem_write;
  assign bus.mdu_busy    = mdu_busy;
  assign bus.mdu_done    = mdu_done;
  assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Cycle-by-cycle scoreboard bench for stall_flush_ctrl with a 4-bit stall counter.
module tb_stall_flush_ctrl;

  localparam int SW = 4;

  // Control vectors in order {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] C_DEF   = 6'b110101;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_BR    = 6'b111111;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b001010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stall_flush_ctrl_if #(.STALL_W(SW)) bus ();

  stall_flush_ctrl #(
    .MULT_CYCLES(4),
    .DIV_CYCLES (32),
    .CNT_W      (6),
    .STALL_W    (SW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef logic [6+2+SW-1:0] obs_t;
  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sc_model = 0;

  always @(posedge clk) begin
    assert (reset || !(bus.mdu_start && bus.mdu_busy))
      else $error("illegal mdu_start while mult/div busy");
  end

  function automatic obs_t observed();
    return {bus.pc_write, bus.ifid_write, bus.ifid_flush, bus.idex_write,
            bus.idex_bubble, bus.exmem_write, bus.mdu_busy, bus.mdu_done, bus.stall_count};
  endfunction

  task automatic set_in(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic mdu,
                        input logic br, input logic st, input logic dv,
                        input logic req, input logic rdy);
    bus.idex_memread = mr;
    bus.idex_rt      = xrt;
    bus.ifid_rs      = rs;
    bus.ifid_rt      = rt;
    bus.ifid_uses_rt = urt;
    bus.ifid_is_mdu  = mdu;
    bus.branch_taken = br;
    bus.mdu_start    = st;
    bus.mdu_is_div   = dv;
    bus.dmem_req     = req;
    bus.dmem_ready   = rdy;
  endtask

  // Push this cycle's expectation; stall_count shown is the count before this cycle.
  task automatic push_exp(input logic [5:0] c, input logic b, input logic d, input logic rst);
    exp_q.push_back({c, b, d, SW'(sc_model)});
    if (rst) sc_model = 0;
    else if (!c[5] && sc_model < (1 << SW) - 1) sc_model++;
  endtask

  task automatic test_reset();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      reset = (i == 0);
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push_exp(i == 0 ? C_RST : C_DEF, 1'b0, 1'b0, i == 0);
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_load_use();
    logic       mr [7] = '{1, 0, 1, 1, 1, 1, 0};
    logic [4:0] xrt[7] = '{5, 5, 0, 7, 7, 9, 0};
    logic [4:0] rs [7] = '{5, 5, 0, 3, 3, 3, 0};
    logic [4:0] rt [7] = '{0, 0, 0, 7, 7, 4, 0};
    logic       urt[7] = '{0, 0, 1, 1, 0, 1, 0};
    logic       stl[7] = '{1, 0, 0, 1, 0, 0, 0};
    obs_t got, want;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      set_in(mr[i], xrt[i], rs[i], rt[i], urt[i], 0, 0, 0, 0, 0, 0);
      push_exp(stl[i] ? C_STALL : C_DEF, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use row%0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_branch();
    obs_t got, want;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) set_in(1, 5, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      else        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push_exp(i == 0 ? C_BR : C_DEF, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch_over_load_use cyc%0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_mdu(input logic is_div);
    int   n = is_div ? 32 : 4;
    obs_t got, want;
    for (int k = 0; k <= n + 1; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, is_div, 0, 0);
        push_exp(C_DEF, 1'b0, 1'b0, 1'b0);
      end else if (k <= n) begin
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        push_exp(C_STALL, 1'b1, k == n, 1'b0);
      end else begin
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        push_exp(C_DEF, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL mdu_%s cyc%0d: got %b required %b", is_div ? "div" : "mult", k, got, want);
      end
    end
  endtask

  task automatic test_freeze_branch();
    obs_t got, want;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      case (i)
        0, 1, 2: begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); push_exp(C_FRZ, 0, 0, 0); end
        3:       begin set_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1); push_exp(C_BR, 0, 0, 0); end
        4:       begin set_in(1, 6, 6, 0, 0, 0, 0, 0, 0, 1, 0); push_exp(C_FRZ, 0, 0, 0); end
        default: begin set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push_exp(C_DEF, 0, 0, 0); end
      endcase
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL freeze_branch cyc%0d: got %b required %b", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    obs_t got, want;
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      reset = (k == 10);
      if (k == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        push_exp(C_DEF, 1'b0, 1'b0, 1'b0);
      end else begin
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        if (k < 10)       push_exp(C_STALL, 1'b1, 1'b0, 1'b0);
        else if (k == 10) push_exp(C_RST, 1'b0, 1'b0, 1'b1);
        else              push_exp(C_DEF, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_mid_div cyc%0d: got %b required %b", k, got, want);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    obs_t got, want;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      reset = (i == 0);
      if (i == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp(C_RST, 1'b0, 1'b0, 1'b1);
      end else if (i <= 20) begin
        set_in(1, 12, 3, 12, 1, 0, 0, 0, 0, 0, 0);
        push_exp(C_STALL, 1'b0, 1'b0, 1'b0);
      end else begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_exp(C_DEF, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk);
      got = observed(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturation cyc%0d: got %b required %b", i, got, want);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_branch();
    test_mdu(1'b0);
    test_mdu(1'b1);
    test_freeze_branch();
    test_reset_mid_div();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
